// File: rtl/hazard_pkg.sv
// Shared types and defaults for the Lapido pipeline interlock controller.
package hazard_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 255;
    localparam int TO_W_DEF    = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = 5'b00001;
    localparam ctrl_t CTRL_BRANCH = 5'b11110;
    localparam ctrl_t CTRL_BUBBLE = 5'b00010;
    localparam ctrl_t CTRL_NORMAL = 5'b11000;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-interlock signal bundle; master is the pipeline, slave is hazard_unit.
interface hazard_unit_if #(
    parameter int CNT_W = hazard_pkg::CNT_W_DEF
);
    logic [3:0]       if_id_registerA;
    logic [3:0]       if_id_registerB;
    logic             if_id_useA;
    logic             if_id_useB;
    logic             id_ex_memRead;
    logic             id_ex_regWrite;
    logic [3:0]       id_ex_registerRD;
    logic             ex_branchTaken;
    logic             mem_busy;
    logic             clear_counters;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output if_id_registerA, if_id_registerB, if_id_useA, if_id_useB,
               id_ex_memRead, id_ex_regWrite, id_ex_registerRD,
               ex_branchTaken, mem_busy, clear_counters,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
               mem_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  if_id_registerA, if_id_registerB, if_id_useA, if_id_useB,
               id_ex_memRead, id_ex_regWrite, id_ex_registerRD,
               ex_branchTaken, mem_busy, clear_counters,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
               mem_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; one-cycle update, clear takes precedence over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_unit.sv
// Stall/flush interlock: combinational controls from ID/EX compare, branch and mem_busy,
// plus a registered memory-wait watchdog FSM and saturating stall/flush statistics.
module hazard_unit #(
    parameter int CNT_W   = hazard_pkg::CNT_W_DEF,
    parameter int TIMEOUT = hazard_pkg::TIMEOUT_DEF,
    parameter int TO_W    = hazard_pkg::TO_W_DEF
) (
    input logic          clock,
    input logic          reset_n,
    hazard_unit_if.slave hz
);
    import hazard_pkg::*;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    hz_state_e       state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_timeout_q, mem_timeout_d;

    logic  load_use;
    logic  freeze;
    ctrl_t ctrl;
    logic  stall_inc;
    logic  flush_inc;

    // No hard-wired zero register, so every source compares against RD.
    assign load_use = hz.id_ex_memRead & hz.id_ex_regWrite &
                      ((hz.if_id_useA & (hz.if_id_registerA == hz.id_ex_registerRD)) |
                       (hz.if_id_useB & (hz.if_id_registerB == hz.id_ex_registerRD)));

    assign freeze = (state_q == ST_FAULT) | hz.mem_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;

        if (hz.mem_busy) begin
            if (wait_cnt_q != '1) begin
                wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
        end else begin
            wait_cnt_d = '0;
        end

        // wait_cnt_q holds busy cycles already seen, so TO_LAST means this is the TIMEOUT-th.
        case (state_q)
            ST_RUN: begin
                if (hz.mem_busy) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!hz.mem_busy)             state_d = ST_RUN;
                else if (wait_cnt_q == TO_LAST) state_d = ST_FAULT;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_RUN;
        endcase

        if (state_d == ST_FAULT) mem_timeout_d = 1'b1;
    end

    always_comb begin
        ctrl      = CTRL_NORMAL;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (freeze) begin
            ctrl      = CTRL_FREEZE;
            stall_inc = (state_q != ST_FAULT);
        end else if (hz.ex_branchTaken) begin
            ctrl      = CTRL_BRANCH;
            flush_inc = 1'b1;
        end else if (load_use) begin
            ctrl      = CTRL_BUBBLE;
            stall_inc = 1'b1;
        end
    end

    // Reset only masks the port view; counters are already held clear by their own reset.
    assign hz.pc_write    = reset_n ? ctrl.pc_write    : CTRL_FREEZE.pc_write;
    assign hz.if_id_write = reset_n ? ctrl.if_id_write : CTRL_FREEZE.if_id_write;
    assign hz.if_id_flush = reset_n ? ctrl.if_id_flush : CTRL_FREEZE.if_id_flush;
    assign hz.id_ex_flush = reset_n ? ctrl.id_ex_flush : CTRL_FREEZE.id_ex_flush;
    assign hz.pipe_hold   = reset_n ? ctrl.pipe_hold   : CTRL_FREEZE.pipe_hold;
    assign hz.mem_timeout = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (stall_inc),
        .clr_i   (hz.clear_counters),
        .cnt_o   (hz.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (flush_inc),
        .clr_i   (hz.clear_counters),
        .cnt_o   (hz.flush_events)
    );
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit with small counter/watchdog parameters.
module tb_hazard_unit;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0]       ctl;
        logic             to;
        logic [CNT_W-1:0] st;
        logic [CNT_W-1:0] fl;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    hazard_unit_if #(.CNT_W(CNT_W)) hz ();

    hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (hz.slave)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Reference model: fault flag, run length of busy cycles, plain integer counters.
    bit m_fault = 0;
    int m_busy_run = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic drv(input logic rst, input logic [3:0] a, input logic [3:0] b,
                       input logic ua, input logic ub, input logic mr, input logic rw,
                       input logic [3:0] rd, input logic br, input logic busy,
                       input logic clr);
        exp_t e;
        bit   lu;
        bit   st_inc;
        bit   fl_inc;
        @(negedge clock);
        reset_n                = rst;
        hz.if_id_registerA     = a;
        hz.if_id_registerB     = b;
        hz.if_id_useA          = ua;
        hz.if_id_useB          = ub;
        hz.id_ex_memRead       = mr;
        hz.id_ex_regWrite      = rw;
        hz.id_ex_registerRD    = rd;
        hz.ex_branchTaken      = br;
        hz.mem_busy            = busy;
        hz.clear_counters      = clr;
        #1;
        if (!rst) begin
            m_fault = 0; m_busy_run = 0; m_stall = 0; m_flush = 0;
            e.ctl = 5'b00001; e.to = 1'b0; e.st = '0; e.fl = '0;
        end else begin
            lu = mr && rw && ((ua && a == rd) || (ub && b == rd));
            st_inc = 0;
            fl_inc = 0;
            if (m_fault || busy) begin
                e.ctl = 5'b00001; st_inc = !m_fault;
            end else if (br) begin
                e.ctl = 5'b11110; fl_inc = 1;
            end else if (lu) begin
                e.ctl = 5'b00010; st_inc = 1;
            end else begin
                e.ctl = 5'b11000;
            end
            e.to = m_fault;
            e.st = m_stall[CNT_W-1:0];
            e.fl = m_flush[CNT_W-1:0];
            m_busy_run = busy ? m_busy_run + 1 : 0;
            if (m_busy_run >= TIMEOUT) m_fault = 1;
            if (clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (st_inc && m_stall < CNT_MAX) m_stall++;
                if (fl_inc && m_flush < CNT_MAX) m_flush++;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1, 0, 0, 0, 0, 0, 0, 4'd9, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        logic [4:0] act_ctl;
        forever begin
            @(negedge clock);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cyc++;
                act_ctl = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_flush, hz.pipe_hold};
                n_checks++;
                if (act_ctl !== e.ctl) begin
                    n_errors++;
                    $display("FAIL ctl cycle %0d: got %b want %b", cyc, act_ctl, e.ctl);
                end
                n_checks++;
                if ({hz.mem_timeout, hz.stall_cycles, hz.flush_events} !== {e.to, e.st, e.fl}) begin
                    n_errors++;
                    $display("FAIL regs cycle %0d: got to=%0d st=%0d fl=%0d want to=%0d st=%0d fl=%0d",
                             cyc, hz.mem_timeout, hz.stall_cycles, hz.flush_events, e.to, e.st, e.fl);
                end
            end
        end
    end

    initial begin : guard
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        hz.if_id_registerA = '0; hz.if_id_registerB = '0; hz.if_id_useA = 0;
        hz.if_id_useB = 0; hz.id_ex_memRead = 0; hz.id_ex_regWrite = 0;
        hz.id_ex_registerRD = '0; hz.ex_branchTaken = 0; hz.mem_busy = 0;
        hz.clear_counters = 0;

        // Reset state, including hazards presented during reset.
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 5, 0, 1, 0, 1, 1, 5, 1, 1, 0);
        idle(2);

        // Load-use on A, then on B, then same registers without use.
        drv(1, 5, 0, 1, 0, 1, 1, 5, 0, 0, 0);
        drv(1, 0, 5, 0, 1, 1, 1, 5, 0, 0, 0);
        drv(1, 5, 5, 0, 0, 1, 1, 5, 0, 0, 0);
        drv(1, 5, 0, 1, 0, 0, 1, 5, 0, 0, 0);
        drv(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
        idle(1);

        // Branch wins over load-use.
        drv(1, 5, 0, 1, 0, 1, 1, 5, 1, 0, 0);
        idle(1);

        // Freeze with pending branch: 3 busy, then flush once.
        for (int i = 0; i < 3; i++) drv(1, 5, 0, 1, 0, 1, 1, 5, 1, 1, 0);
        drv(1, 5, 0, 1, 0, 1, 1, 5, 1, 0, 0);
        idle(2);

        // Watchdog restart: 3 busy, 1 idle, 3 busy.
        for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // Watchdog fault, sticky after busy drops, cleared by reset.
        for (int i = 0; i < 5; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(1, 5, 0, 1, 0, 1, 1, 5, 1, 0, 0);
        idle(2);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Counter saturation, then clear concurrent with a stall.
        for (int i = 0; i < 20; i++) drv(1, 3, 0, 1, 0, 1, 1, 3, 0, 0, 0);
        drv(1, 3, 0, 1, 0, 1, 1, 3, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 18; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom_range(0, 59) != 0),
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 49) == 0));
        end

        idle(1);
        repeat (3) @(negedge clock);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline interlock controller for the Lapido core: the stall/flush side of hazard resolution, complementing the bypass muxes driven by forwarding. It inspects the instruction in IF/ID against the instruction in ID/EX, the EX-stage branch outcome and the data-memory busy line. From these it drives PC/IF-ID write enables, bubble/flush controls and a pipeline freeze. It also runs a memory-wait watchdog and saturating stall/flush statistics counters.

## Interface
- CNT_W, 16, width of statistics counters
- TIMEOUT, 255, consecutive `mem_busy` cycles that trigger the fault state (≥2)
- TO_W, 8, watchdog counter width; TIMEOUT ≤ 2^TO_W − 1

- clock  in  1  rising-edge clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- if_id_registerA  in  4  source A of the instruction in ID
- if_id_registerB  in  4  source B of the instruction in ID
- if_id_useA  in  1  ID instruction reads A
- if_id_useB  in  1  ID instruction reads B (register operand, not immediate)
- id_ex_memRead  in  1  EX instruction is a load
- id_ex_regWrite  in  1  EX instruction writes a register
- id_ex_registerRD  in  4  destination of the EX instruction
- ex_branchTaken  in  1  branch/jump resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; MEM stage must hold
- clear_counters  in  1  synchronous clear of statistics counters
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may load
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load bubble into ID/EX
- pipe_hold  out  1  EX/MEM and MEM/WB hold their contents
- mem_timeout  out  1  sticky watchdog fault, registered
- stall_cycles  out  CNT_W  cycles with `pc_write`=0 outside reset/FAULT, saturating
- flush_events  out  CNT_W  branch flushes applied, saturating

## Operation
- All 16 registers are real; no register is hard-wired zero, so there is no R0 exclusion in compares.
- States: RUN, WAIT, FAULT.
  - RUN→WAIT when `mem_busy`=1 at the edge.
  - WAIT→RUN when `mem_busy`=0.
  - WAIT→FAULT at the edge where the TIMEOUT-th consecutive busy cycle is sampled.
  - FAULT is exited only by reset.
- Watchdog `wait_cnt` increments on each busy cycle and is zeroed on any non-busy cycle.
- Control decode, highest priority first:
  1. FAULT, or `mem_busy`=1 (freeze): `pc_write`=0, `if_id_write`=0, `pipe_hold`=1, both flushes 0.
  2. `ex_branchTaken`: `pc_write`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_flush`=1, `pipe_hold`=0. Load-use is ignored because the ID instruction is discarded.
  3. Load-use: `id_ex_memRead` & `id_ex_regWrite` & ((`if_id_useA` & A==RD) | (`if_id_useB` & B==RD)). Drive `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `pipe_hold`=0. A single bubble suffices; MEM/WB forwarding covers the next cycle.
  4. Otherwise: `pc_write`=1, `if_id_write`=1, flushes 0, `pipe_hold`=0.
- Counters:
  - `stall_cycles` increments on cases 1 and 3 while in RUN or WAIT.
  - `flush_events` increments on case 2.
  - Both saturate at all-ones.
  - `clear_counters` overrides increment in the same cycle.

## Timing
- Control outputs are combinational from inputs and current state; zero-cycle latency, the stall acts in the same cycle the hazard is visible.
- `mem_timeout`, the counters, state and `wait_cnt` are registered and update on the rising edge.
- Reset values:
  - State RUN, `wait_cnt`=0, `mem_timeout`=0, counters 0.
  - While `reset_n`=0, combinational outputs are forced to `pc_write`=0, `if_id_write`=0, `pipe_hold`=1, flushes 0.
- Reset asserted mid-WAIT or in FAULT returns to RUN immediately (asynchronous); normal decode resumes on the first edge after release.
- `mem_busy` and `ex_branchTaken` together: freeze wins. EX is frozen, so the branch stays asserted and its flush applies on the first non-busy cycle; `flush_events` counts it once.
- `mem_busy` and load-use together: freeze only. The load-use condition is re-evaluated after the freeze ends.
- `mem_timeout` rises one edge after the fault condition and stays at 1.

## Structure
- Shared package/header `hazard_pkg`: state encoding (RUN=2'd0, WAIT=2'd1, FAULT=2'd2), default CNT_W/TIMEOUT values.
- One sub-module, `sat_counter`: CNT_W-wide, with inc, sync clr and async active-low reset. It is instantiated twice, for `stall_cycles` and `flush_events`.
- Hazard compare, FSM and watchdog live in `hazard_unit`.

## Test plan
- **Load-use stall:** ID/EX load to R5, IF/ID with A=5 and `useA`=1.
  - Same cycle: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1.
  - `stall_cycles` goes 0→1.
  - With `useA`=0, no stall.
- **Branch flush:** `ex_branchTaken`=1 together with a load-use match.
  - Outputs: `if_id_flush`=1, `id_ex_flush`=1, `pc_write`=1.
  - `flush_events`=1, `stall_cycles` unchanged.
- **Freeze with pending branch:** `mem_busy` high for 3 cycles, `ex_branchTaken` held.
  - During the 3 cycles: `pipe_hold`=1 and no flush.
  - Cycle 4: flush pulses once.
  - End values: `stall_cycles`=3, `flush_events`=1.
- **Watchdog:** TIMEOUT=4, `mem_busy` held high.
  - `mem_timeout`=1 after the 4th busy edge.
  - Dropping `mem_busy` keeps the freeze and the fault.
  - `reset_n` pulse clears everything.
- **Watchdog restart:** 3 busy cycles, 1 idle cycle, 3 busy cycles with TIMEOUT=4 → no fault.
- **Counter limits:** CNT_W=4.
  - 20 stall cycles → `stall_cycles` holds at 15.
  - `clear_counters` concurrent with a stall → 0 next cycle.
